subterranean_hash_sequencer: RTL and testbench
==============================================

Name: subterranean_hash_sequencer

Overview:
- Autonomous hash/XOF command sequencer for the subterranean_simple_no_communication core.
- Accepts a byte-serial message on a valid/ready stream and issues the full Subterranean hash command sequence to the core: init, absorb, padding, blank rounds, squeeze.
- Returns a digest of parametrised length as a 32-bit word stream with backpressure.
- Replaces host/testbench-driven command sequencing; sits between a message FIFO and the core.

Parameters:
- DIGEST_WORDS, 8, number of 32-bit squeeze words per digest (1..16); default gives a 256-bit digest.
- BLANK_ROUNDS, 8, number of empty duplex calls between padding and squeeze (1..31).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a hash; honoured only in IDLE.
- msg_empty  in  1  sampled with start; 1 = zero-length message, and no stream bytes are consumed.
- s_data  in  8  message byte.
- s_valid  in  1  byte valid.
- s_last  in  1  marks the final message byte.
- s_ready  out  1  byte accepted when s_valid&s_ready.
- m_data  out  32  digest word.
- m_valid  out  1  digest word valid.
- m_last  out  1  marks the final digest word.
- m_ready  in  1  digest word accepted when m_valid&m_ready.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last digest word is accepted.
- core_start_operation  out  1  command strobe to the core.
- core_operation_type  out  4  0=init, 2=duplex_simple_incomplete, 7=squeeze.
- core_buffer_in  out  32  command operand.
- core_buffer_in_size  out  2  operand size code.
- core_buffer_out  in  32  core squeeze output.
- core_free  in  1  core idle and able to take a command.
- core_finish  in  1  core completion pulse.

Behaviour:
- Reset: every output is 0; operation_type=0; buffer_in_size=0; state IDLE. Reset mid-operation abandons the hash immediately. The core is not reset by this block; the next command waits for core_free.
- Command issue, ISSUE/WAIT pair for every command:
  - In ISSUE, with core_free=1, drive core_start_operation=1 with type/operand/size for exactly one cycle.
  - Then WAIT for core_finish. Outside ISSUE, start=0, type=0, buffer_in=0, size=2'b11.
  - A command is never issued while core_free=0.
- States and transitions:
  - IDLE: busy=0. On start go to INIT and latch msg_empty; start outside IDLE is ignored.
  - INIT: type 0, buffer_in 0, size 11.
  - ABS_BYTE (skipped if msg_empty): s_ready=1 for one cycle only after the core is free, capturing the byte and last flag. Then issue type 2, buffer_in={23'b0,1'b1,byte} (0x100|byte), size 01.
  - ABS_BLANK: type 2, buffer_in 0x00000001, size 00. Go to ABS_BYTE if the captured last=0, else PAD.
  - PAD: two calls of type 2, buffer_in 0x00000001, size 00.
  - BLANK: BLANK_ROUNDS calls of type 2, 0x00000001, size 00.
  - SQUEEZE: type 7, buffer_in 0x00000001, size 11. On core_finish, register core_buffer_out into m_data and set m_valid=1, go to OUT.
  - OUT: hold m_data/m_valid stable until m_ready. m_last=1 on word DIGEST_WORDS-1. The next squeeze is not issued until the word is accepted. After the last word go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- s_ready is 0 outside the ABS_BYTE capture cycle. Bytes presented early are held by the upstream; none are dropped or duplicated.
- Counters:
  - Byte count is unbounded; termination is by s_last only.
  - Blank/pad counter is 5 bits. The squeeze counter is ceil(log2(DIGEST_WORDS+1)) bits.
  - Counters clear on entry to their state.
- Word order: the first squeezed word leaves first. Bytes within a word are passed exactly as core_buffer_out, with no swapping.
- Command count per hash: 1 + 2·N + 2 + BLANK_ROUNDS + DIGEST_WORDS, where N is the message length in bytes.

Test Plan:
- msg_empty=1, defaults -> exactly 19 core commands (1 init, 2 pad, 8 blank, 8 squeeze). The 8 digest words equal the Count=1 vector of LWC_HASH_KAT_256.txt. done pulses once.
- 1-byte message 0xA5 with s_last=1 -> core commands include buffer_in=0x000001A5 size 01, followed by 0x00000001 size 00. 21 commands total; the digest matches the KAT.
- Full KAT sweep (lengths 0..1024 bytes, core_finish latency as modelled by the core) -> every digest matches; s_ready pulses exactly N times.
- Hold m_ready=0 for 5 cycles on word 3 -> m_data stable, no core_start_operation during the hold. The digest is unchanged versus the no-stall run.
- DIGEST_WORDS=4, BLANK_ROUNDS=2, empty message -> 9 commands. m_last is set only on the 4th word, which equals the first 4 words of the default digest only if BLANK_ROUNDS matches; the check is against the reference model.
- Assert rst during ABS_BYTE of a 10-byte message -> the next cycle all outputs are 0 and the state is IDLE. A fresh start after core_free=1 produces the correct KAT digest; start during busy is ignored.

Source files
------------

// File: rtl/subterranean_hash_sequencer.sv
// Subterranean hash/XOF command sequencer: takes a byte stream, issues
// init/absorb/pad/blank/squeeze commands to the core, and streams the digest.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, msg_empty          begin a hash; msg_empty=1 means zero-length message
//   s_data/s_valid/s_last/s_ready   message byte stream in
//   m_data/m_valid/m_last/m_ready   32-bit digest word stream out
//   busy, done                hash in progress / one-cycle completion pulse
//   core_*                    command interface to the Subterranean core
module subterranean_hash_sequencer #(
    parameter int DIGEST_WORDS = 8,
    parameter int BLANK_ROUNDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        msg_empty,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        busy,
    output logic        done,
    output logic        core_start_operation,
    output logic [3:0]  core_operation_type,
    output logic [31:0] core_buffer_in,
    output logic [1:0]  core_buffer_in_size,
    input  logic [31:0] core_buffer_out,
    input  logic        core_free,
    input  logic        core_finish
);

    localparam int WW = $clog2(DIGEST_WORDS + 1);
    localparam logic [4:0]    BLANK_LAST = 5'(BLANK_ROUNDS - 1);
    localparam logic [WW-1:0] WORD_LAST  = WW'(DIGEST_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_GET, S_BYTE, S_ABLANK,
        S_PAD, S_BLANK, S_SQZ, S_OUT, S_DONE
    } state_t;

    state_t        state;
    logic          pending;   // command strobed, waiting for core_finish
    logic          empty_q;
    logic [7:0]    byte_q;
    logic          last_q;
    logic [4:0]    cnt;
    logic [WW-1:0] wcnt;

    logic        is_cmd;
    logic [3:0]  cmd_type;
    logic [31:0] cmd_buf;
    logic [1:0]  cmd_size;

    // Command fields belonging to each command-issuing state.
    always_comb begin
        is_cmd   = 1'b1;
        cmd_type = 4'd2;
        cmd_buf  = 32'h0000_0001;
        cmd_size = 2'b00;
        case (state)
            S_INIT: begin
                cmd_type = 4'd0;
                cmd_buf  = 32'h0;
                cmd_size = 2'b11;
            end
            S_BYTE: begin
                cmd_buf  = {23'b0, 1'b1, byte_q};
                cmd_size = 2'b01;
            end
            S_ABLANK, S_PAD, S_BLANK: ;
            S_SQZ: begin
                cmd_type = 4'd7;
                cmd_size = 2'b11;
            end
            default: begin
                is_cmd   = 1'b0;
                cmd_type = 4'd0;
                cmd_buf  = 32'h0;
                cmd_size = 2'b11;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            pending              <= 1'b0;
            empty_q              <= 1'b0;
            byte_q               <= 8'h0;
            last_q               <= 1'b0;
            cnt                  <= 5'd0;
            wcnt                 <= '0;
            s_ready              <= 1'b0;
            m_data               <= 32'h0;
            m_valid              <= 1'b0;
            m_last               <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            core_start_operation <= 1'b0;
            core_operation_type  <= 4'd0;
            core_buffer_in       <= 32'h0;
            core_buffer_in_size  <= 2'b00;
        end else begin
            done                 <= 1'b0;
            core_start_operation <= 1'b0;
            core_operation_type  <= 4'd0;
            core_buffer_in       <= 32'h0;
            if (state != S_IDLE)
                core_buffer_in_size <= 2'b11;

            if (is_cmd) begin
                if (!pending) begin
                    if (core_free) begin
                        core_start_operation <= 1'b1;
                        core_operation_type  <= cmd_type;
                        core_buffer_in       <= cmd_buf;
                        core_buffer_in_size  <= cmd_size;
                        pending              <= 1'b1;
                    end
                end else if (core_finish) begin
                    pending <= 1'b0;
                    case (state)
                        S_INIT: begin
                            cnt   <= 5'd0;
                            state <= empty_q ? S_PAD : S_GET;
                        end
                        S_BYTE: state <= S_ABLANK;
                        S_ABLANK: begin
                            cnt   <= 5'd0;
                            state <= last_q ? S_PAD : S_GET;
                        end
                        S_PAD: begin
                            if (cnt == 5'd1) begin
                                cnt   <= 5'd0;
                                state <= S_BLANK;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                        S_BLANK: begin
                            if (cnt == BLANK_LAST) begin
                                wcnt  <= '0;
                                state <= S_SQZ;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                        S_SQZ: begin
                            m_data  <= core_buffer_out;
                            m_valid <= 1'b1;
                            m_last  <= (wcnt == WORD_LAST);
                            state   <= S_OUT;
                        end
                        default: ;
                    endcase
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        empty_q <= msg_empty;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                        state   <= S_INIT;
                    end
                end
                // Open the byte window only once the core can take the absorb.
                S_GET: begin
                    if (!s_ready) begin
                        if (core_free)
                            s_ready <= 1'b1;
                    end else if (s_valid) begin
                        byte_q  <= s_data;
                        last_q  <= s_last;
                        s_ready <= 1'b0;
                        state   <= S_BYTE;
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (wcnt == WORD_LAST) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            wcnt  <= wcnt + 1'b1;
                            state <= S_SQZ;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subterranean_hash_sequencer.sv
// Bench for subterranean_hash_sequencer: a stand-in core that mixes every
// command into a 32-bit state, and a command-list model of each hash.
module tb_subterranean_hash_sequencer;

    localparam int DW = 8;
    localparam int BR = 8;
    localparam logic [31:0] IV = 32'h811C_9DC5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        msg_empty = 1'b0;
    logic [7:0]  s_data = 8'h0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        core_start_operation;
    logic [3:0]  core_operation_type;
    logic [31:0] core_buffer_in;
    logic [1:0]  core_buffer_in_size;
    logic [31:0] core_buffer_out = 32'h0;
    logic        core_free = 1'b1;
    logic        core_finish = 1'b0;

    subterranean_hash_sequencer #(.DIGEST_WORDS(DW), .BLANK_ROUNDS(BR)) dut (
        .clk(clk), .rst(rst), .start(start), .msg_empty(msg_empty),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done(done),
        .core_start_operation(core_start_operation),
        .core_operation_type(core_operation_type),
        .core_buffer_in(core_buffer_in),
        .core_buffer_in_size(core_buffer_in_size),
        .core_buffer_out(core_buffer_out),
        .core_free(core_free), .core_finish(core_finish)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0]  msg[$];
    logic [37:0] exp_cmd[$];
    logic [37:0] log_q[$];
    logic [31:0] exp_w[DW];
    logic [31:0] got_w[DW];
    logic [31:0] ref_w[DW];
    int hs_cnt = 0, done_cnt = 0, out_idx = 0, b_idx = 0;
    int hold_n = 0, stall_word = -1, core_lat = 0;
    bit hs_pend = 0, held = 0, feeding = 0, pend_sqz = 0;
    logic [32:0] held_val = '0;
    logic [31:0] cst = IV;

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mix(input logic [31:0] st,
                                        input logic [3:0] t,
                                        input logic [31:0] b,
                                        input logic [1:0] sz);
        logic [31:0] x;
        x = (st ^ b ^ {sz, 26'b0, t}) * 32'h0100_0193;
        return {x[18:0], x[31:13]} ^ 32'h9E37_79B9;
    endfunction

    // Expected command list and digest straight from the hash recipe.
    function automatic void build_model();
        logic [31:0] st;
        int k;
        exp_cmd.delete();
        exp_cmd.push_back({4'd0, 32'h0, 2'b11});
        foreach (msg[i]) begin
            exp_cmd.push_back({4'd2, 32'h100 | {24'h0, msg[i]}, 2'b01});
            exp_cmd.push_back({4'd2, 32'h1, 2'b00});
        end
        repeat (2) exp_cmd.push_back({4'd2, 32'h1, 2'b00});
        repeat (BR) exp_cmd.push_back({4'd2, 32'h1, 2'b00});
        repeat (DW) exp_cmd.push_back({4'd7, 32'h1, 2'b11});
        st = IV;
        k = 0;
        foreach (exp_cmd[i]) begin
            if (exp_cmd[i][37:34] == 4'd0)
                st = IV;
            else
                st = mix(st, exp_cmd[i][37:34], exp_cmd[i][33:2], exp_cmd[i][1:0]);
            if (exp_cmd[i][37:34] == 4'd7 && k < DW) begin
                exp_w[k] = st;
                k++;
            end
        end
    endfunction

    // Stand-in core, stream source/sink and per-cycle checks.
    always @(negedge clk) begin
        bit free_seen;
        free_seen = core_free;
        core_finish = 1'b0;
        if (core_lat > 0) begin
            core_lat--;
            if (core_lat == 0) begin
                core_finish = 1'b1;
                core_free = 1'b1;
                if (pend_sqz) core_buffer_out = cst;
            end
        end
        if (core_start_operation) begin
            chk("cmd_while_core_busy", free_seen, 1);
            log_q.push_back({core_operation_type, core_buffer_in, core_buffer_in_size});
            if (core_operation_type == 4'd0)
                cst = IV;
            else
                cst = mix(cst, core_operation_type, core_buffer_in, core_buffer_in_size);
            pend_sqz = (core_operation_type == 4'd7);
            core_free = 1'b0;
            core_lat = $urandom_range(1, 4);
        end

        if (!rst) begin
            if (!core_start_operation)
                chk("idle_cmd_fields", {core_operation_type, core_buffer_in}, 0);
            if (m_valid) begin
                chk("no_cmd_during_out", core_start_operation, 0);
                if (held) chk("m_hold_stable", {m_last, m_data}, held_val);
            end
            if (done) begin
                done_cnt++;
                chk("done_busy_low", busy, 0);
            end
        end

        if (hs_pend) begin
            hs_pend = 0;
            if (feeding) begin
                b_idx++;
                s_valid = 1'b0;
            end
        end
        if (s_valid && s_ready) begin
            hs_pend = 1;
            hs_cnt++;
        end else if (feeding && !s_valid && b_idx < msg.size()
                     && $urandom_range(0, 3) != 0) begin
            s_valid = 1'b1;
            s_data = msg[b_idx];
            s_last = (b_idx == msg.size() - 1);
        end

        if (m_valid && out_idx == stall_word && hold_n < 5) begin
            m_ready = 1'b0;
            hold_n++;
        end else begin
            m_ready = ($urandom_range(0, 2) != 0);
        end
        if (!rst && m_valid && m_ready) begin
            if (out_idx < DW) begin
                chk("digest_word", m_data, exp_w[out_idx]);
                chk("m_last", m_last, out_idx == DW - 1);
                got_w[out_idx] = m_data;
            end else begin
                chk("extra_word", out_idx, DW - 1);
            end
            out_idx++;
            held = 0;
        end else begin
            held = m_valid;
            held_val = {m_last, m_data};
        end
    end

    task automatic check_zero(input string name);
        chk({name, "_a"}, {s_ready, m_data, m_valid, m_last, busy, done}, 0);
        chk({name, "_b"}, {core_start_operation, core_operation_type,
                           core_buffer_in, core_buffer_in_size}, 0);
    endtask

    task automatic start_hash(input int n, input int stall, input bit fix,
                              input logic [7:0] first);
        @(posedge clk); #2;
        msg.delete();
        for (int i = 0; i < n; i++)
            msg.push_back((fix && i == 0) ? first : 8'($urandom));
        build_model();
        log_q.delete();
        hs_cnt = 0; done_cnt = 0; out_idx = 0; b_idx = 0;
        hs_pend = 0; hold_n = 0; held = 0; stall_word = stall;
        feeding = (n > 0);
        s_valid = (n == 0);
        s_data = 8'h3C;
        s_last = 1'b1;
        start = 1'b1;
        msg_empty = (n == 0);
        @(posedge clk); #2;
        start = 1'b0;
        msg_empty = 1'($urandom);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic finish_hash(input int n);
        int cyc;
        int mism;
        cyc = 0;
        while (done_cnt == 0 && cyc < 8000) begin
            @(posedge clk);
            cyc++;
        end
        chk("done_timeout", done_cnt != 0, 1);
        repeat (3) @(posedge clk);
        #2;
        chk("done_once", done_cnt, 1);
        chk("busy_end", busy, 0);
        chk("s_ready_pulses", hs_cnt, n);
        chk("word_count", out_idx, DW);
        chk("cmd_count", log_q.size(), 1 + 2 * n + 2 + BR + DW);
        mism = -1;
        foreach (exp_cmd[i])
            if (mism < 0 && (i >= log_q.size() || log_q[i] !== exp_cmd[i]))
                mism = i;
        chk("cmd_seq_bad_at", mism + 1, 0);
        s_valid = 1'b0;
        feeding = 0;
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_state");
        rst = 1'b0;

        start_hash(0, -1, 0, 8'h0);
        finish_hash(0);
        chk("empty_19_cmds", log_q.size(), 19);
        chk("init_cmd", log_q[0], {4'd0, 32'h0, 2'b11});
        chk("pad_cmd", log_q[1], {4'd2, 32'h1, 2'b00});
        chk("first_sqz_cmd", log_q[11], {4'd7, 32'h1, 2'b11});
        foreach (got_w[i]) ref_w[i] = got_w[i];

        start_hash(1, -1, 1, 8'hA5);
        finish_hash(1);
        chk("one_byte_21_cmds", log_q.size(), 21);
        chk("byte_cmd_a5", log_q[1], {4'd2, 32'h0000_01A5, 2'b01});
        chk("byte_blank_cmd", log_q[2], {4'd2, 32'h1, 2'b00});

        start_hash(0, 3, 0, 8'h0);
        finish_hash(0);
        chk("stall_hold_len", hold_n, 5);
        foreach (got_w[i]) chk("stall_same_digest", got_w[i], ref_w[i]);

        for (int t = 0; t < 8; t++) begin
            int n;
            n = (t == 7) ? 40 : $urandom_range(2, 24);
            start_hash(n, $urandom_range(0, DW - 1), 0, 8'h0);
            finish_hash(n);
        end

        start_hash(10, -1, 0, 8'h0);
        cyc = 0;
        while (!(b_idx >= 3 && s_ready) && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        chk("reach_abs_byte", s_ready, 1);
        #2;
        rst = 1'b1;
        feeding = 0;
        s_valid = 1'b0;
        @(posedge clk); #2;
        check_zero("mid_reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_zero("after_reset_idle");

        start_hash(6, -1, 0, 8'h0);
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1;
        msg_empty = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        finish_hash(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
